// File: rtl/xfifo_reader.sv
// xfifo_reader: converts a one-cycle-latency fifo read port into a ready/valid
// stream through a 3-entry in-order output buffer.
module xfifo_reader #(
  parameter int dta_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [dta_width-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  input  logic                 fifo_empty,
  input  logic                 fifo_valid,
  input  logic                 fifo_underflow,
  output logic [dta_width-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_underflow,
  output logic                 err_protocol,
  output logic [15:0]          word_count
);

  logic [dta_width-1:0] r_buf [0:2];
  logic [1:0]           r_rd_ptr;
  logic [1:0]           r_wr_ptr;
  logic [1:0]           r_occ;
  logic                 r_pending;
  logic                 r_err_underflow;
  logic                 r_err_protocol;
  logic [15:0]          r_word_count;

  logic                 w_push;
  logic                 w_pop;
  logic [2:0]           w_reserved;
  logic [2:0]           w_wr_sel;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A slot is reserved as soon as a read is issued, so an in-flight word
  // always has somewhere to land; out_ready plays no part here.
  assign w_reserved = {1'b0, r_occ} + {2'b00, r_pending};
  assign fifo_rd_en = ~rst & ~fifo_empty & (w_reserved < 3'd3);

  assign w_push     = fifo_valid & r_pending;
  assign w_pop      = out_valid & out_ready;
  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = (r_rd_ptr == 2'd2) ? r_buf[2] :
                      (r_rd_ptr == 2'd1) ? r_buf[1] : r_buf[0];

  assign err_underflow = r_err_underflow;
  assign err_protocol  = r_err_protocol;
  assign word_count    = r_word_count;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_entry
      assign w_wr_sel[gi] = w_push & (r_wr_ptr == 2'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_buf[gi] <= '0;
        end else if (w_wr_sel[gi]) begin
          r_buf[gi] <= fifo_dout;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr        <= 2'd0;
      r_wr_ptr        <= 2'd0;
      r_occ           <= 2'd0;
      r_pending       <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_protocol  <= 1'b0;
      r_word_count    <= 16'd0;
    end else begin
      r_pending <= fifo_rd_en;
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr     <= ptr_inc(r_rd_ptr);
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 2'd1;
      end else if (!w_push && w_pop) begin
        r_occ <= r_occ - 2'd1;
      end
      if (fifo_underflow) begin
        r_err_underflow <= 1'b1;
      end
      // An acknowledge with no read outstanding is dropped, never buffered.
      if (fifo_valid && !r_pending) begin
        r_err_protocol <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_xfifo_reader.sv
// Bench for xfifo_reader: behavioural one-cycle-latency fifo plus a scoreboard
// of expected words, one task per scenario.
module tb_xfifo_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic        fifo_valid;
  logic        fifo_underflow;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_underflow;
  logic        err_protocol;
  logic [15:0] word_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:1023];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         gen_cnt = 0;
  logic       gen_mode = 1'b0;
  logic       f_valid = 1'b0;
  logic       f_notempty = 1'b0;
  logic [7:0] f_dout = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_underflow = 1'b0;
  logic [7:0] m_dout = 8'h00;
  logic       cap_rd = 1'b0;
  logic       cap_has = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign fifo_empty     = ~gen_mode & (rd_cnt == wr_cnt) & ~f_notempty;
  assign fifo_valid     = m_valid | f_valid;
  assign fifo_underflow = m_underflow;
  assign fifo_dout      = f_valid ? f_dout : m_dout;

  xfifo_reader #(.dta_width(8)) dut (
    .clk(clk), .rst(rst),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .fifo_underflow(fifo_underflow),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_underflow(err_underflow), .err_protocol(err_protocol),
    .word_count(word_count)
  );

  // Fifo model: a read issued in one cycle answers in the next.
  always @(negedge clk) begin
    cap_rd  = fifo_rd_en;
    cap_has = gen_mode || (rd_cnt != wr_cnt);
  end

  always @(posedge clk) begin
    #1;
    m_valid     = 1'b0;
    m_underflow = 1'b0;
    if (cap_rd) begin
      if (cap_has) begin
        m_valid = 1'b1;
        if (gen_mode) begin
          m_dout  = gen_cnt[7:0];
          gen_cnt = gen_cnt + 1;
        end else begin
          m_dout = mem[rd_cnt % 1024];
          rd_cnt = rd_cnt + 1;
        end
      end else begin
        m_underflow = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    mem[wr_cnt % 1024] = v;
    wr_cnt = wr_cnt + 1;
    exp_q.push_back(v);
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b required 0", fifo_rd_en); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %0h required 0", out_data); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_word_count: got %0d required 0", word_count); end
    checks++; if ({err_underflow, err_protocol} !== 2'b00) begin errors++; $display("FAIL rst_errs: got %b required 00", {err_underflow, err_protocol}); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL release_rd_en_empty: got %0b required 0", fifo_rd_en); end
    tick();
  endtask

  task automatic test_stream();
    int first_rd = -1;
    int first_val = -1;
    int last_val = -1;
    logic [7:0] exp;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) load(8'(i));
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (fifo_rd_en && first_rd < 0) first_rd = cyc;
      if (out_valid && out_ready) begin
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %0h required no word", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin errors++; $display("FAIL stream_data: got %0h required %0h", out_data, exp); end
        end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (first_val - first_rd !== 2) begin errors++; $display("FAIL stream_latency: got %0d required 2", first_val - first_rd); end
    checks++; if (last_val - first_val !== 7) begin errors++; $display("FAIL stream_no_bubbles: got span %0d required 7", last_val - first_val); end
    checks++; if (word_count !== 16'd8) begin errors++; $display("FAIL stream_word_count: got %0d required 8", word_count); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_left: got %0d required 0", exp_q.size()); end
    tick();
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    logic [7:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) load(8'h10 + 8'(i));
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
      if (out_valid) begin
        checks++;
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL bp_hold: got %0h required %0h", out_data, exp_q[0]); end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (pulses !== 3) begin errors++; $display("FAIL bp_rd_pulses: got %0d required 3", pulses); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0b required 1", out_valid); end
    tick();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL bp_data: got %0h required %0h", out_data, exp); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_toggle();
    logic rd_now;
    logic [7:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) load(8'h40 + 8'(i));
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      rd_now = fifo_rd_en;
      out_ready = ~out_ready;
      #1;
      checks++;
      if (fifo_rd_en !== rd_now) begin errors++; $display("FAIL toggle_rd_en_indep: got %0b required %0b", fifo_rd_en, rd_now); end
      out_ready = ~out_ready;
      #1;
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL toggle_data: got %0h required %0h", out_data, exp); end
      end
      tick();
      out_ready = ~out_ready;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL toggle_drain: got %0d left required 0", exp_q.size()); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL toggle_dup: got out_valid %0b data %0h required 0", out_valid, out_data); end
      tick();
    end
  endtask

  task automatic test_errors();
    logic [7:0] exp;
    out_ready = 1'b1;
    f_valid = 1'b1;
    f_dout  = 8'hAA;
    tick();
    f_valid = 1'b0;
    @(negedge clk);
    checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL protocol_flag: got %0b required 1", err_protocol); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL protocol_discard: got out_valid %0b data %0h required 0", out_valid, out_data); end
      tick();
      @(negedge clk);
    end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL underflow_pre: got %0b required 0", err_underflow); end
    tick();
    f_notempty = 1'b1;
    tick();
    f_notempty = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %0b required 1", err_underflow); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL underflow_occ: got out_valid %0b required 0", out_valid); end
    tick();
    load(8'h5C);
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL underflow_after: got %0h required %0h", out_data, exp); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL underflow_slot: got %0d left required 0", exp_q.size()); end
    checks++; if ({err_underflow, err_protocol} !== 2'b11) begin errors++; $display("FAIL errs_sticky: got %b required 11", {err_underflow, err_protocol}); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    load(8'h81);
    load(8'h82);
    load(8'h83);
    tick();
    tick();
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %0b required 1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %0b required 0", out_valid); end
    checks++; if (word_count !== 16'd0) begin errors++; $display("FAIL arst_word_count: got %0d required 0", word_count); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL arst_data: got %0h required 0", out_data); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_rd_en: got %0b required 0", fifo_rd_en); end
    checks++; if ({err_underflow, err_protocol} !== 2'b00) begin errors++; $display("FAIL arst_errs: got %b required 00", {err_underflow, err_protocol}); end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    f_valid = 1'b1;
    f_dout = 8'h77;
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL arst_release_rd_en: got %0b required 0", fifo_rd_en); end
    tick();
    f_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (err_protocol !== 1'b1) begin errors++; $display("FAIL arst_protocol: got %0b required 1", err_protocol); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_discard: got out_valid %0b data %0h required 0", out_valid, out_data); end
      tick();
      @(negedge clk);
    end
    tick();
  endtask

  task automatic test_wrap();
    int delivered = 0;
    int gen_exp = 0;
    logic [7:0] exp;
    out_ready = 1'b1;
    gen_mode = 1'b1;
    for (int cyc = 0; cyc < 70000 && delivered < 65537; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp = gen_exp[7:0];
        checks++;
        if (out_data !== exp) begin errors++; $display("FAIL wrap_data: got %0h required %0h at word %0d", out_data, exp, delivered); end
        gen_exp = gen_exp + 1;
        delivered++;
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (delivered !== 65537) begin errors++; $display("FAIL wrap_budget: got %0d words required 65537", delivered); end
    @(negedge clk);
    checks++; if (word_count !== 16'd1) begin errors++; $display("FAIL wrap_word_count: got %0d required 1", word_count); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_toggle();
    test_errors();
    test_async_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xfifo_reader.md
XFIFO_READER -- requirements
Module: xfifo_reader

Interface
REQ-001 Parameter: dta_width, default 8, data word width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: fifo_dout  input  dta_width  read data from the fifo read port.
REQ-005 Port: fifo_rd_en  output  1  read enable to the fifo.
REQ-006 Port: fifo_empty  input  1  fifo empty flag.
REQ-007 Port: fifo_valid  input  1  fifo read acknowledge; fifo_dout carries the word in the same cycle.
REQ-008 Port: fifo_underflow  input  1  fifo read error for the previous cycle's rd_en.
REQ-009 Port: out_data  output  dta_width  head-of-buffer word to the consumer.
REQ-010 Port: out_valid  output  1  out_data holds a valid word.
REQ-011 Port: out_ready  input  1  consumer accepts the word; transfer when out_valid && out_ready.
REQ-012 Port: err_underflow  output  1  sticky: fifo_underflow seen.
REQ-013 Port: err_protocol  output  1  sticky: fifo_valid seen with no read pending.
REQ-014 Port: word_count  output  16  words delivered to the consumer since reset.

Function
REQ-015 The block SHALL convert the fifo's one-cycle-latency read port (rd_en -> valid/dout next cycle) into a ready/valid stream.
REQ-016 It SHALL hold a 3-entry in-order output buffer; occ (0..3) is the registered occupancy.
REQ-017 Register pending SHALL equal fifo_rd_en of the previous cycle.
REQ-018 fifo_rd_en SHALL be ~fifo_empty && (occ + pending < 3); it SHALL have no combinational dependence on out_ready.
REQ-019 Push: fifo_valid && pending -> fifo_dout written to buffer tail at end of cycle.
REQ-020 Pop: out_valid && out_ready -> head removed; next entry becomes out_data on the next cycle.
REQ-021 Simultaneous push and pop SHALL leave occ unchanged and preserve order; push into occ==3 without pop cannot occur by REQ-018.
REQ-022 out_valid SHALL equal (occ != 0); out_data SHALL be stable while out_valid && ~out_ready.
REQ-023 First-word latency: fifo_rd_en in cycle N, fifo_valid in N+1, out_valid in N+2.
REQ-024 Steady state with out_ready held high and fifo non-empty: one word per cycle, no bubbles.
REQ-025 pending && ~fifo_valid: no push; slot released; err_underflow set if fifo_underflow is high.
REQ-026 fifo_valid && ~pending: word discarded, err_protocol set, occ unchanged.
REQ-027 Sticky error flags SHALL clear only on reset.
REQ-028 word_count SHALL increment by 1 per pop, 16-bit, wrapping 65535 -> 0.
REQ-029 Buffer pointers SHALL wrap modulo 3.

Reset
REQ-030 While rst is high: fifo_rd_en=0, out_valid=0, out_data=0, err_underflow=0, err_protocol=0, word_count=0, occ=0, pending=0, buffer pointers=0.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight words; a fifo_valid in the first cycle after release SHALL set err_protocol.
REQ-032 fifo_rd_en SHALL be 0 in the first cycle after release only if fifo_empty is 1; otherwise it follows REQ-018.

Verification
REQ-033 Fifo preloaded with 0x01..0x08, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive cycles, first out_valid 2 cycles after first rd_en; word_count=8.
REQ-034 out_ready=0, fifo holds 10 words -> exactly 3 rd_en pulses, occ=3, out_data=first word stable; raise out_ready -> remaining 7 delivered in order.
REQ-035 out_ready toggling 1/0 each cycle, 20 words -> all 20 in order, none lost or duplicated, fifo_rd_en never depends on same-cycle out_ready.
REQ-036 Force fifo_valid=1 with pending=0 -> err_protocol=1, word not delivered; force fifo_underflow after rd_en -> err_underflow=1, occ unchanged.
REQ-037 Deliver 65537 words -> word_count=1.
REQ-038 Assert rst with occ=2 and a read pending -> out_valid=0, word_count=0 immediately (asynchronous), both words discarded.
